// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and default width
// for the bit-serial gate sequencer.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_ADD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bit_alu_slice.sv
// One-bit ALU slice: selects a gate output or
// a full-adder sum/carry built from the gate cells.
import alu_pkg::*;

module bit_alu_slice (
    input  logic [2:0] op,
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       c_in,
    output logic       f,
    output logic       c_out
);

    logic y_not;
    logic y_and;
    logic y_or;
    logic y_nand;
    logic y_nor;
    logic y_xor;
    logic y_xnor;
    logic y_sum;
    logic y_cp;
    logic y_maj;

    gate_not  u_not  (.a(a_bit), .y(y_not));
    gate_and  u_and  (.a(a_bit), .b(b_bit), .y(y_and));
    gate_or   u_or   (.a(a_bit), .b(b_bit), .y(y_or));
    gate_nand u_nand (.a(a_bit), .b(b_bit), .y(y_nand));
    gate_nor  u_nor  (.a(a_bit), .b(b_bit), .y(y_nor));
    gate_xor  u_xor  (.a(a_bit), .b(b_bit), .y(y_xor));
    gate_xnor u_xnor (.a(a_bit), .b(b_bit), .y(y_xnor));

    // majority(a,b,c) = ab | c(a^b)
    gate_xor  u_sum  (.a(y_xor), .b(c_in), .y(y_sum));
    gate_and  u_cp   (.a(y_xor), .b(c_in), .y(y_cp));
    gate_or   u_maj  (.a(y_and), .b(y_cp), .y(y_maj));

    always_comb begin
        f     = 1'b0;
        c_out = 1'b0;
        unique case (op)
            OP_NOT:  f = y_not;
            OP_AND:  f = y_and;
            OP_OR:   f = y_or;
            OP_NAND: f = y_nand;
            OP_NOR:  f = y_nor;
            OP_XOR:  f = y_xor;
            OP_XNOR: f = y_xnor;
            OP_ADD: begin
                f     = y_sum;
                c_out = y_maj;
            end
            default: f = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_cells.sv
// 1-bit primitive gate cells used to build
// the serial ALU slice.
module gate_not (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module gate_and (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module gate_or (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module gate_nand (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module gate_nor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a | b);
endmodule

module gate_xor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module gate_xnor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a ^ b);
endmodule

// File: rtl/gate_sequencer.sv
// Bit-serial gate/adder sequencer: captures a request,
// computes one result bit per cycle, holds it until taken.
import alu_pkg::*;

module gate_sequencer #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             capture;
    logic             step;
    logic             f_bit;
    logic             c_next;

    bit_alu_slice u_slice (
        .op    (op_q),
        .a_bit (a_q[cnt_q]),
        .b_bit (b_q[cnt_q]),
        .c_in  (carry_q),
        .f     (f_bit),
        .c_out (c_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        capture   = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else if (capture) begin
            cnt_q   <= '0;
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else if (step) begin
            res_q[cnt_q] <= f_bit;
            carry_q      <= c_next;
            if (cnt_q != LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign result    = res_q;
    assign carry_out = (op_q == OP_ADD) & carry_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer (WIDTH=8) with an
// expected-result queue popped when out_valid shows up.
import alu_pkg::*;

module tb_gate_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry_out;
    logic       busy;

    int n_chk;
    int n_pass;
    logic [8:0] sb[$];

    gate_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] model(
        input logic [2:0] o,
        input logic [7:0] x,
        input logic [7:0] y
    );
        case (o)
            OP_NOT:  return {1'b0, ~x};
            OP_AND:  return {1'b0, x & y};
            OP_OR:   return {1'b0, x | y};
            OP_NAND: return {1'b0, ~(x & y)};
            OP_NOR:  return {1'b0, ~(x | y)};
            OP_XOR:  return {1'b0, x ^ y};
            OP_XNOR: return {1'b0, ~(x ^ y)};
            default: return {1'b0, x} + {1'b0, y};
        endcase
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Waits up to 40 edges for out_valid; returns edges seen.
    task automatic wait_done(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_out(input string tag);
        logic [8:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 9'h1xx;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_result"}, 32'(result), 32'(exp[7:0]));
        chk({tag, "_carry"}, 32'(carry_out), 32'(exp[8]));
    endtask

    // Issue one request with out_ready=1; called at a negedge.
    task automatic run_op(
        input string      tag,
        input logic [2:0] o,
        input logic [7:0] x,
        input logic [7:0] y
    );
        int edges;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        op        = o;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sb.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(edges);
        // 8 bit edges follow the capture edge: 9 edges in all
        chk({tag, "_latency"}, 32'(edges), 32'd8);
        check_out(tag);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int  edges;
        bit  seen_valid;
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("and_ca_0f", OP_AND, 8'hCA, 8'h0F);
        run_op("add_ff_01", OP_ADD, 8'hFF, 8'h01);
        run_op("add_35_4a", OP_ADD, 8'h35, 8'h4A);
        run_op("not_5a", OP_NOT, 8'h5A, 8'hFF);
        run_op("xnor_3c", OP_XNOR, 8'h3C, 8'h3C);
        run_op("nor_0c_30", OP_NOR, 8'h0C, 8'h30);

        // Backpressure with a pending new request
        op        = OP_OR;
        a         = 8'hA0;
        b         = 8'h05;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sb.push_back(model(OP_OR, 8'hA0, 8'h05));
        @(posedge clk);
        #1;
        op = OP_AND;
        a  = 8'hF0;
        b  = 8'h3C;
        chk("bp_busy", 32'(busy), 32'd1);
        wait_done(edges);
        chk("bp_latency", 32'(edges), 32'd8);
        check_out("bp_first");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_result", 32'(result), 32'hA5);
            chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        sb.push_back(model(OP_AND, 8'hF0, 8'h3C));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_hs_in_ready", 32'(in_ready), 32'd1);
        chk("bp_hs_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("bp_capture_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        wait_done(edges);
        chk("bp_second_latency", 32'(edges), 32'd8);
        check_out("bp_second");
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);

        // Reset while processing bit 3
        op       = OP_ADD;
        a        = 8'hFF;
        b        = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        out_ready  = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        chk("mid_rst_no_valid", 32'(seen_valid), 32'd0);
        run_op("or_after_rst", OP_OR, 8'hF0, 8'h0F);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
